// File: rtl/argmax_collect_pkg.sv
// Shared constants and state encoding for the argmax score collector.
package argmax_collect_pkg;

    localparam int ARGMAX_N  = 16;
    localparam int ARGMAX_M  = 32;
    localparam int ARGMAX_CW = 5;

    // Minimum score value, so padded slots can never win the argmax.
    localparam logic [ARGMAX_M-1:0] PAD_VAL = 32'h0000_0000;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/argmax_collect.sv
// Packs a stream of M-bit scores into an N-slot frame for the argmax chain,
// padding short frames (closed by in_last) with the minimum score.
module argmax_collect #(
    parameter int                N       = argmax_collect_pkg::ARGMAX_N,
    parameter int                M       = argmax_collect_pkg::ARGMAX_M,
    parameter int                CW      = argmax_collect_pkg::ARGMAX_CW,
    parameter logic [M-1:0]      PAD_VAL = argmax_collect_pkg::PAD_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M-1:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*M-1:0]    out_data,
    output logic [CW-1:0]     out_count
);

    import argmax_collect_pkg::*;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [M-1:0]  slot_q [N];
    logic [M-1:0]  slot_d [N];
    logic          accept;
    logic          close;
    logic [N-1:0]  pad_en;

    function automatic logic [N-1:0] pad_mask(input logic [CW-1:0] idx);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[i] = (CW'(i) > idx);
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= PAD_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // cnt_q is always 0 in HOLD, so a word accepted during the frame
    // transfer follows exactly the same slot-0 path as a FILL acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        for (int i = 0; i < N; i++) begin
            slot_d[i] = slot_q[i];
        end
        accept = in_valid && in_ready;
        close  = in_last || (cnt_q == CW'(N-1));
        pad_en = pad_mask(cnt_q);

        if (state_q == HOLD && out_ready) begin
            state_d = FILL;
            cnt_d   = '0;
        end

        if (accept) begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) == cnt_q) begin
                    slot_d[i] = in_data;
                end else if (close && pad_en[i]) begin
                    slot_d[i] = PAD_VAL;
                end
            end
            if (close) begin
                count_d = cnt_q + 1'b1;
                cnt_d   = '0;
                state_d = HOLD;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = FILL;
            end
        end
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = !rst && ((state_q == FILL) || out_ready);
        out_count = count_q;
        out_data  = '0;
        for (int i = 0; i < N; i++) begin
            out_data[i*M +: M] = slot_q[i];
        end
    end

endmodule

// File: tb/tb_argmax_collect.sv
// Directed, table-driven bench for argmax_collect with hand-computed frames.
module tb_argmax_collect;

    import argmax_collect_pkg::*;

    localparam int N  = ARGMAX_N;
    localparam int M  = ARGMAX_M;
    localparam int CW = ARGMAX_CW;
    localparam int FW = N*M;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [M-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [FW-1:0] out_data;
    logic [CW-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          iv;
        logic [M-1:0]  d;
        logic          l;
        logic          ordy;
        logic          exp_ir;
        logic          exp_ov;
        logic [CW-1:0] exp_cnt;
        logic [M-1:0]  exp_s0;
        logic          chk_rest;
    } vec_t;

    vec_t vecs [13];

    argmax_collect dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge; the caller samples before the next rising edge.
    task automatic apply_stimulus(input logic v, input logic [M-1:0] d, input logic l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
    endtask

    function automatic logic [FW-1:0] put(input logic [FW-1:0] f, input int idx, input logic [M-1:0] v);
        f[idx*M +: M] = v;
        return f;
    endfunction

    initial begin
        logic [FW-1:0] frame;
        logic [FW-1:0] frame2;

        vecs[0]  = '{1'b1, 32'd10,  1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h55, 1'b0};
        vecs[1]  = '{1'b1, 32'd20,  1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'd10, 1'b0};
        vecs[2]  = '{1'b1, 32'd30,  1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'd10, 1'b0};
        vecs[3]  = '{1'b1, 32'd40,  1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'd10, 1'b0};
        vecs[4]  = '{1'b1, 32'd50,  1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'd10, 1'b0};
        vecs[5]  = '{1'b1, 32'd99,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'd10, 1'b0};
        vecs[6]  = '{1'b1, 32'd99,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'd10, 1'b0};
        vecs[7]  = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'd10, 1'b0};
        vecs[8]  = '{1'b1, 32'hA,   1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'd10, 1'b0};
        vecs[9]  = '{1'b1, 32'hB,   1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 32'hA,  1'b1};
        vecs[10] = '{1'b1, 32'hC,   1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 32'hB,  1'b1};
        vecs[11] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'hC,  1'b1};
        vecs[12] = '{1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 32'hC,  1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_output("reset out_valid", FW'(out_valid), FW'(1'b0));
        check_output("reset out_count", FW'(out_count), FW'(0));
        check_output("reset out_data", out_data, {N{PAD_VAL}});
        check_output("reset in_ready", FW'(in_ready), FW'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post-reset in_ready", FW'(in_ready), FW'(1'b1));

        // Full frame of i*3
        frame = '0;
        for (int i = 0; i < N; i++) begin
            apply_stimulus(1'b1, M'(i*3), 1'b0, 1'b1);
            check_output("full fill in_ready", FW'(in_ready), FW'(1'b1));
            check_output("full fill out_valid", FW'(out_valid), FW'(1'b0));
            frame = put(frame, i, M'(i*3));
        end
        apply_stimulus(1'b1, M'(100), 1'b0, 1'b1);
        check_output("full out_valid", FW'(out_valid), FW'(1'b1));
        check_output("full in_ready", FW'(in_ready), FW'(1'b1));
        check_output("full out_count", FW'(out_count), FW'(16));
        check_output("full out_data", out_data, frame);

        // Second full frame, then backpressure
        frame2 = put(frame, 0, M'(100));
        for (int i = 1; i < N; i++) begin
            apply_stimulus(1'b1, M'(200+i), 1'b0, 1'b1);
            if (i == 1) begin
                check_output("frame2 out_valid low", FW'(out_valid), FW'(1'b0));
                check_output("frame2 slot0", FW'(out_data[M-1:0]), FW'(100));
            end
            frame2 = put(frame2, i, M'(200+i));
        end
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(1'b1, M'('h55), 1'b0, 1'b0);
            check_output("bp in_ready", FW'(in_ready), FW'(1'b0));
            check_output("bp out_valid", FW'(out_valid), FW'(1'b1));
            check_output("bp out_data", out_data, frame2);
            check_output("bp out_count", FW'(out_count), FW'(16));
        end
        apply_stimulus(1'b1, M'('h55), 1'b0, 1'b1);
        check_output("bp release in_ready", FW'(in_ready), FW'(1'b1));
        check_output("bp release out_valid", FW'(out_valid), FW'(1'b1));
        apply_stimulus(1'b1, M'('h66), 1'b1, 1'b1);
        check_output("bp next out_valid", FW'(out_valid), FW'(1'b0));
        check_output("bp next slot0", FW'(out_data[M-1:0]), FW'('h55));
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("two-word out_valid", FW'(out_valid), FW'(1'b1));
        check_output("two-word out_count", FW'(out_count), FW'(2));
        frame = put(put('0, 0, M'('h55)), 1, M'('h66));
        check_output("two-word out_data", out_data, frame);

        // Short frame and back-to-back single-word frames
        frame = '0;
        for (int i = 0; i < 5; i++) begin
            frame = put(frame, i, M'((i+1)*10));
        end
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].iv, vecs[i].d, vecs[i].l, vecs[i].ordy);
            check_output($sformatf("vec%0d in_ready", i), FW'(in_ready), FW'(vecs[i].exp_ir));
            check_output($sformatf("vec%0d out_valid", i), FW'(out_valid), FW'(vecs[i].exp_ov));
            check_output($sformatf("vec%0d out_count", i), FW'(out_count), FW'(vecs[i].exp_cnt));
            check_output($sformatf("vec%0d slot0", i), FW'(out_data[M-1:0]), FW'(vecs[i].exp_s0));
            if (vecs[i].chk_rest) begin
                check_output($sformatf("vec%0d pad slots", i), FW'(out_data[FW-1:M]), '0);
            end
            if (i == 5) begin
                check_output("short out_data", out_data, frame);
            end
        end

        // Asynchronous reset mid-frame
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b1, M'('h1000+i), 1'b0, 1'b1);
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async rst out_valid", FW'(out_valid), FW'(1'b0));
        check_output("async rst out_count", FW'(out_count), FW'(0));
        check_output("async rst out_data", out_data, {N{PAD_VAL}});
        @(negedge clk);
        rst = 1'b0;
        frame = '0;
        for (int i = 0; i < N; i++) begin
            apply_stimulus(1'b1, M'('h2000+i), 1'b0, 1'b1);
            frame = put(frame, i, M'('h2000+i));
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("post-rst frame out_valid", FW'(out_valid), FW'(1'b1));
        check_output("post-rst frame out_count", FW'(out_count), FW'(16));
        check_output("post-rst frame out_data", out_data, frame);

        // Auto-close overflow: 20 words, no in_last
        frame = '0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, M'('h3000+i), 1'b0, 1'b1);
            if (i == 16) begin
                check_output("ovf frame1 out_valid", FW'(out_valid), FW'(1'b1));
                check_output("ovf frame1 out_count", FW'(out_count), FW'(16));
                check_output("ovf frame1 out_data", out_data, frame);
            end
            if (i < N) begin
                frame = put(frame, i, M'('h3000+i));
            end
        end
        for (int i = 0; i < 4; i++) begin
            frame = put(frame, i, M'('h3010+i));
        end
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        check_output("ovf frame2 out_valid", FW'(out_valid), FW'(1'b0));
        check_output("ovf frame2 in_ready", FW'(in_ready), FW'(1'b1));
        check_output("ovf frame2 out_data", out_data, frame);
        check_output("ovf frame2 out_count", FW'(out_count), FW'(16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
